nfc_ahb_slave: RTL

Parametrised AHB-Lite slave front-end for the NAND flash controller. It replaces the fixed 32-bit, zero-wait bus signal bundle with a real slave that owns the controller's configuration register file. The slave inserts programmable wait states, supports byte/halfword/word (and doubleword) lane writes, and generates the two-cycle AHB ERROR response for illegal accesses and injected faults. It sits between the system AHB matrix and the NFC core; the core sees only `ctrl_o` and `sts_i`.

---
 rtl/nfc_ahb_slave.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/nfc_ahb_slave.sv
// -----------------------------------------------------------------------------
// nfc_ahb_slave
// AHB-Lite slave front-end for the NAND flash controller. Owns the controller's
// configuration register file. It inserts WAIT_CYCLES wait states per OKAY data
// phase, performs byte/halfword/word(/doubleword) lane writes and answers illegal
// accesses with the two-cycle ERROR response.
//
// Optional feature macro: NFC_AHB_FAULT_INJ_EN
//   When it is defined, fault_injection=1 at acceptance forces an ERROR response.
//   When it is undefined, fault_injection is ignored.
//
// Parameters: DATA_W (32|64), ADDR_W, NUM_REGS (2..64), WAIT_CYCLES (0..15)
// Ports:
//   HCLK, HRESET       clock, asynchronous active-low reset
//   HSEL .. HWDATA     AHB-Lite address/control/write-data inputs
//                      (HBURST, HPROT and HMASTLOCK are accepted but unused)
//   HRDATA, HREADYOUT, HRESP   AHB-Lite slave response
//   fault_injection    forces ERROR on the next accepted transfer (when enabled)
//   ctrl_o             contents of register 0
//   sts_i              value returned on reads of read-only register 1
// -----------------------------------------------------------------------------
module nfc_ahb_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [1:0]        HTRANS,
  input  logic              HMASTLOCK,
  input  logic              HREADY,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  input  logic              fault_injection,
  output logic [DATA_W-1:0] ctrl_o,
  input  logic [DATA_W-1:0] sts_i
);

  localparam int NBYTES = DATA_W / 8;
  localparam int LSB    = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int IDXF_W = ADDR_W - LSB;
  localparam logic [2:0] MAX_SIZE  = 3'(LSB);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_cnt, w_cnt_nxt;
  logic               r_pend, w_pend_nxt;   // an OKAY data phase is in progress
  logic [IDX_W-1:0]   r_idx;
  logic [LSB-1:0]     r_off;
  logic [2:0]         r_size;
  logic               r_write;
  logic [DATA_W-1:0]  r_regs [NUM_REGS];

  logic [IDXF_W-1:0]  w_idx_full;
  logic [LSB-1:0]     w_off;
  logic               w_misaligned, w_idx_oob, w_wr_ro, w_fault, w_err;
  logic               w_accept, w_done;
  logic [NBYTES-1:0]  w_be;
  logic [DATA_W-1:0]  w_rd_val;

`ifdef NFC_AHB_FAULT_INJ_EN
  assign w_fault = fault_injection;
  logic w_unused;
  assign w_unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};
`else
  assign w_fault = 1'b0;
  logic w_unused;
  assign w_unused = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], fault_injection};
`endif

  // Address-phase decode.
  assign w_idx_full   = HADDR[ADDR_W-1:LSB];
  assign w_off        = HADDR[LSB-1:0];
  assign w_misaligned = |(8'(w_off) & ((8'd1 << HSIZE) - 8'd1));
  assign w_idx_oob    = 32'(w_idx_full) >= 32'(NUM_REGS);
  assign w_wr_ro      = HWRITE && (w_idx_full == IDXF_W'(1));
  assign w_err        = (HSIZE > MAX_SIZE) | w_misaligned | w_idx_oob | w_wr_ro | w_fault;

  // HREADYOUT gates acceptance so that no address is taken during a wait or ERR1.
  assign HREADYOUT = !((r_state == S_WAIT && r_cnt != 4'd0) || r_state == S_ERR1);
  assign HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign w_accept  = HSEL & HREADY & HTRANS[1] & HREADYOUT;
  assign w_done    = r_pend && (r_state == S_IDLE || (r_state == S_WAIT && r_cnt == 4'd0));

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pend_nxt  = r_pend;
    if (r_state == S_ERR1) begin
      w_state_nxt = S_ERR2;
    end else if (!HREADYOUT) begin
      w_cnt_nxt = r_cnt - 4'd1;
    end else if (w_accept) begin
      if (w_err) begin
        w_state_nxt = S_ERR1;
        w_pend_nxt  = 1'b0;
      end else if (WAIT_INIT != 4'd0) begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = WAIT_INIT;
        w_pend_nxt  = 1'b1;
      end else begin
        w_state_nxt = S_IDLE;
        w_pend_nxt  = 1'b1;
      end
    end else begin
      w_state_nxt = S_IDLE;
      w_pend_nxt  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      r_idx   <= '0;
      r_off   <= '0;
      r_size  <= 3'd0;
      r_write <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= w_idx_full[IDX_W-1:0];
      r_off   <= w_off;
      r_size  <= HSIZE;
      r_write <= HWRITE;
    end
  end

  // Byte lanes covered by the latched size and offset.
  always_comb begin
    w_be = '0;
    for (int b = 0; b < NBYTES; b++)
      w_be[b] = (b >= int'(r_off)) && (b < int'(r_off) + (1 << r_size));
  end

  // NOTE: the register file is small and software-visible, so it is reset
  // explicitly; large storage arrays would normally be left unreset.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_done && r_write) begin
      for (int b = 0; b < NBYTES; b++)
        if (w_be[b]) r_regs[r_idx][8*b +: 8] <= HWDATA[8*b +: 8];
    end
  end

  assign w_rd_val = (r_idx == IDX_W'(1)) ? sts_i : r_regs[r_idx];
  assign HRDATA   = (w_done && !r_write) ? w_rd_val : '0;
  assign ctrl_o   = r_regs[0];

endmodule
